// File: rtl/sad_search_ctrl.sv
// sad_search_ctrl: block-matching search controller. Walks NUM_CAND candidate
// windows of WORDS 32-bit words and reports the candidate with the smallest
// sum of absolute byte differences against a reference block.
// Optional feature: define SAD_EARLY_TERM_EN to stop reading a candidate as
// soon as its running sum can no longer beat the best found so far.
// Address arithmetic assumes ADDR_W <= 32.

module sad4x8 (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [9:0]  sad_o
);
  function automatic logic [9:0] absd(input logic [7:0] x, input logic [7:0] y);
    return (x >= y) ? {2'b00, x - y} : {2'b00, y - x};
  endfunction

  assign sad_o = absd(a_i[7:0],   b_i[7:0])   + absd(a_i[15:8],  b_i[15:8]) +
                 absd(a_i[23:16], b_i[23:16]) + absd(a_i[31:24], b_i[31:24]);
endmodule

// state | meaning
// IDLE  | waiting for start
// ISSUE | one read per cycle, word index first, then candidate
// DRAIN | last read returning, final compare
// DONE  | one-cycle done pulse
module sad_search_ctrl #(
  parameter int WORDS     = 16,
  parameter int NUM_CAND  = 8,
  parameter int CAND_STEP = 1,
  parameter int ADDR_W    = 12
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] frm_base_i,
  input  logic [ADDR_W-1:0] win_base_i,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] frm_addr_o,
  output logic [ADDR_W-1:0] win_addr_o,
  input  logic [31:0]       frm_data_i,
  input  logic [31:0]       win_data_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [15:0]       best_sad_o,
  output logic [7:0]        best_idx_o
);
  localparam logic [5:0] W_LAST = 6'(WORDS - 1);
  localparam logic [7:0] C_LAST = 8'(NUM_CAND - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t            state_q;
  logic              rd_en_q, busy_q, done_q;
  logic [ADDR_W-1:0] frm_base_q, win_base_q, frm_addr_q, win_addr_q;
  logic [5:0]        iw_q, pw_q;
  logic [7:0]        ic_q, pc_q;
  logic              pvld_q;
  logic [15:0]       acc_q, best_sad_q;
  logic [7:0]        best_idx_q;

  logic [9:0]        word_sad;
  logic [15:0]       acc_d;
  logic              last_word, term, issue_end;
  logic [5:0]        nw_d;
  logic [7:0]        nc_d;
  logic [ADDR_W-1:0] frm_addr_d, win_addr_d;

  sad4x8 u_sad (
    .a_i   (frm_data_i),
    .b_i   (win_data_i),
    .sad_o (word_sad)
  );

  // Accumulate returning word, decide early stop and the next (c,w) to issue.
  // pw_q/pc_q tag the word arriving this cycle; iw_q/ic_q the address on the bus.
  always_comb begin
    acc_d     = ((pw_q == 6'd0) ? 16'd0 : acc_q) + {6'd0, word_sad};
    last_word = pvld_q && (pw_q == W_LAST);
`ifdef SAD_EARLY_TERM_EN
    term      = pvld_q && (pc_q != 8'd0) && (pw_q != W_LAST) && (acc_d >= best_sad_q);
`else
    term      = 1'b0;
`endif
    nw_d      = iw_q + 6'd1;
    nc_d      = ic_q;
    issue_end = 1'b0;
    if (term) begin
      // Word on the bus still belongs to pc_q; skip straight to the next candidate.
      nw_d      = 6'd0;
      nc_d      = pc_q + 8'd1;
      issue_end = (pc_q == C_LAST);
    end else if (iw_q == W_LAST) begin
      nw_d      = 6'd0;
      nc_d      = ic_q + 8'd1;
      issue_end = (ic_q == C_LAST);
    end
    frm_addr_d = frm_base_q + ADDR_W'(nw_d);
    win_addr_d = win_base_q + ADDR_W'(nc_d) * ADDR_W'(CAND_STEP) + ADDR_W'(nw_d);
  end

  // Sequencer, read pipeline tags, accumulator and best-candidate tracking.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      rd_en_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      frm_base_q <= '0;
      win_base_q <= '0;
      frm_addr_q <= '0;
      win_addr_q <= '0;
      iw_q       <= '0;
      ic_q       <= '0;
      pw_q       <= '0;
      pc_q       <= '0;
      pvld_q     <= 1'b0;
      acc_q      <= '0;
      best_sad_q <= 16'hFFFF;
      best_idx_q <= '0;
    end else begin
      // A word killed by early termination is never accumulated.
      pvld_q <= rd_en_q && !term;
      pw_q   <= iw_q;
      pc_q   <= ic_q;
      if (pvld_q) begin
        acc_q <= acc_d;
        if (last_word && ((pc_q == 8'd0) || (acc_d < best_sad_q))) begin
          best_sad_q <= acc_d;
          best_idx_q <= pc_q;
        end
      end
      case (state_q)
        IDLE: begin
          if (start_i) begin
            frm_base_q <= frm_base_i;
            win_base_q <= win_base_i;
            frm_addr_q <= frm_base_i;
            win_addr_q <= win_base_i;
            iw_q       <= '0;
            ic_q       <= '0;
            rd_en_q    <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= ISSUE;
          end
        end
        ISSUE: begin
          if (issue_end) begin
            rd_en_q <= 1'b0;
            state_q <= DRAIN;
          end else begin
            iw_q       <= nw_d;
            ic_q       <= nc_d;
            frm_addr_q <= frm_addr_d;
            win_addr_q <= win_addr_d;
          end
        end
        DRAIN: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rd_en_o    = rd_en_q;
  assign frm_addr_o = frm_addr_q;
  assign win_addr_o = win_addr_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign best_sad_o = best_sad_q;
  assign best_idx_o = best_idx_q;
endmodule
